// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD combinational read ports, two clocked write ports
// (port 1 has priority), optional write-through bypass, optional zero register, busy scoreboard.
module regfile_mp #(
    parameter int unsigned DW       = 32,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned BYPASS   = 1,
    parameter int unsigned ZERO_REG = 1,
    localparam int unsigned AW      = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_RD*AW-1:0] rd_addr,
    output logic [NUM_RD*DW-1:0] rd_data,
    output logic [NUM_RD-1:0]    rd_busy,
    input  logic                 wr0_en,
    input  logic [AW-1:0]        wr0_addr,
    input  logic [DW-1:0]        wr0_data,
    input  logic                 wr1_en,
    input  logic [AW-1:0]        wr1_addr,
    input  logic [DW-1:0]        wr1_data,
    input  logic                 busy_set_en,
    input  logic [AW-1:0]        busy_set_addr
);

    logic [DW-1:0]    mem [DEPTH];
    logic [DEPTH-1:0] busy;

    logic wr0_commit;
    logic wr1_commit;
    logic set_ok;

    // Address 0 is filtered once here so storage, scoreboard and bypass all agree on it.
    always_comb begin
        wr0_commit = wr0_en;
        wr1_commit = wr1_en;
        set_ok     = busy_set_en;
        if (ZERO_REG != 0) begin
            if (wr0_addr == '0)      wr0_commit = 1'b0;
            if (wr1_addr == '0)      wr1_commit = 1'b0;
            if (busy_set_addr == '0) set_ok     = 1'b0;
        end
    end

    // Port 1 is assigned last so it wins a same-address collision; a set overrides a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < DEPTH; r++) begin
                mem[r] <= '0;
            end
            busy <= '0;
        end else begin
            if (wr0_commit) begin
                mem[wr0_addr]  <= wr0_data;
                busy[wr0_addr] <= 1'b0;
            end
            if (wr1_commit) begin
                mem[wr1_addr]  <= wr1_data;
                busy[wr1_addr] <= 1'b0;
            end
            if (set_ok) begin
                busy[busy_set_addr] <= 1'b1;
            end
        end
    end

    logic [AW-1:0] ra;
    logic [DW-1:0] rv;
    logic          rb;
    logic          hit0;
    logic          hit1;
    logic          set_hit;

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        ra      = '0;
        rv      = '0;
        rb      = 1'b0;
        hit0    = 1'b0;
        hit1    = 1'b0;
        set_hit = 1'b0;
        for (int unsigned i = 0; i < NUM_RD; i++) begin
            ra      = rd_addr[i*AW +: AW];
            rv      = mem[ra];
            rb      = busy[ra];
            hit0    = wr0_commit && (wr0_addr == ra);
            hit1    = wr1_commit && (wr1_addr == ra);
            set_hit = set_ok && (busy_set_addr == ra);
            if (BYPASS != 0) begin
                if (hit1) begin
                    rv = wr1_data;
                end else if (hit0) begin
                    rv = wr0_data;
                end
                if ((hit0 || hit1) && !set_hit) begin
                    rb = 1'b0;
                end
            end
            if ((ZERO_REG != 0) && (ra == '0)) begin
                rv = '0;
                rb = 1'b0;
            end
            // Bypass must not leak write data while the array is held in reset.
            if (!rst_n) begin
                rv = '0;
                rb = 1'b0;
            end
            rd_data[i*DW +: DW] = rv;
            rd_busy[i]          = rb;
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: a bypassing and a non-bypassing instance share stimulus and are
// checked every cycle against an array model, plus literal expectations for each scenario.
module tb_regfile_mp;

    logic        clk;
    logic        rst_n;
    logic [9:0]  rd_addr;
    logic [63:0] rdd_bp;
    logic [63:0] rdd_nb;
    logic [1:0]  rdb_bp;
    logic [1:0]  rdb_nb;
    logic        wr0_en;
    logic [4:0]  wr0_addr;
    logic [31:0] wr0_data;
    logic        wr1_en;
    logic [4:0]  wr1_addr;
    logic [31:0] wr1_data;
    logic        busy_set_en;
    logic [4:0]  busy_set_addr;

    int checks = 0;
    int errors = 0;

    regfile_mp #(.DW(32), .DEPTH(32), .NUM_RD(2), .BYPASS(1), .ZERO_REG(1)) dut (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rdd_bp), .rd_busy(rdb_bp),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .busy_set_en(busy_set_en), .busy_set_addr(busy_set_addr)
    );

    regfile_mp #(.DW(32), .DEPTH(32), .NUM_RD(2), .BYPASS(0), .ZERO_REG(1)) dut_nb (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rdd_nb), .rd_busy(rdb_nb),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .busy_set_en(busy_set_en), .busy_set_addr(busy_set_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state: what each register holds and whether it awaits a producer.
    logic [31:0] m_mem  [32];
    logic        m_busy [32];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < 32; r++) begin
                m_mem[r]  <= 32'h0;
                m_busy[r] <= 1'b0;
            end
        end else begin
            if (wr0_en && wr0_addr != 5'd0) begin
                m_mem[wr0_addr]  <= wr0_data;
                m_busy[wr0_addr] <= 1'b0;
            end
            if (wr1_en && wr1_addr != 5'd0) begin
                m_mem[wr1_addr]  <= wr1_data;
                m_busy[wr1_addr] <= 1'b0;
            end
            if (busy_set_en && busy_set_addr != 5'd0) m_busy[busy_set_addr] <= 1'b1;
        end
    end

    function automatic logic [31:0] exp_data(input bit bp, input logic [4:0] a);
        if (!rst_n || a == 5'd0) return 32'h0;
        if (bp && wr1_en && wr1_addr == a) return wr1_data;
        if (bp && wr0_en && wr0_addr == a) return wr0_data;
        return m_mem[a];
    endfunction

    function automatic logic exp_busy(input bit bp, input logic [4:0] a);
        logic written;
        if (!rst_n || a == 5'd0) return 1'b0;
        written = (wr0_en && wr0_addr == a) || (wr1_en && wr1_addr == a);
        if (bp && written && !(busy_set_en && busy_set_addr == a)) return 1'b0;
        return m_busy[a];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        for (int p = 0; p < 2; p++) begin
            logic [4:0] a;
            a = rd_addr[p*5 +: 5];
            check($sformatf("model_bp_data%0d", p), rdd_bp[p*32 +: 32], exp_data(1'b1, a));
            check($sformatf("model_nb_data%0d", p), rdd_nb[p*32 +: 32], exp_data(1'b0, a));
            check($sformatf("model_bp_busy%0d", p), {31'h0, rdb_bp[p]}, {31'h0, exp_busy(1'b1, a)});
            check($sformatf("model_nb_busy%0d", p), {31'h0, rdb_nb[p]}, {31'h0, exp_busy(1'b0, a)});
        end
    end

    task automatic idle();
        wr0_en = 1'b0; wr1_en = 1'b0; busy_set_en = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
        rd_addr = {a1, a0};
    endtask

    initial begin
        rst_n = 1'b0;
        rd_addr = '0;
        wr0_addr = '0; wr0_data = '0; wr1_addr = '0; wr1_data = '0; busy_set_addr = '0;
        idle();
        // Writes presented during reset must be dropped.
        wr0_en = 1'b1; wr0_addr = 5'd6; wr0_data = 32'h0000_1234;
        step(); step();
        idle();
        rst_n = 1'b1;
        set_rd(5'd6, 5'd5);
        #1;
        check("reset_reg6_dropped", rdd_bp[31:0], 32'h0);
        check("reset_reg5", rdd_nb[63:32], 32'h0);
        check("reset_busy", {30'h0, rdb_bp}, 32'h0);

        // T1: populate reg5 and mark it busy, then pulse reset mid-cycle.
        wr0_en = 1'b1; wr0_addr = 5'd5; wr0_data = 32'hFFFF_FFFF;
        step();
        idle();
        busy_set_en = 1'b1; busy_set_addr = 5'd5;
        step();
        idle();
        #1;
        check("t1_reg5_written", rdd_nb[63:32], 32'hFFFF_FFFF);
        check("t1_reg5_busy", {31'h0, rdb_nb[1]}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("t1_rst_data_bp", rdd_bp[63:32], 32'h0);
        check("t1_rst_data_nb", rdd_nb[63:32], 32'h0);
        check("t1_rst_busy", {30'h0, rdb_bp | rdb_nb}, 32'h0);
        step();
        rst_n = 1'b1;
        #1;
        check("t1_after_release", rdd_bp[63:32], 32'h0);

        // T2: basic write then read on two ports.
        wr0_en = 1'b1; wr0_addr = 5'd1; wr0_data = 32'h2100_00CA;
        step();
        idle();
        set_rd(5'd1, 5'd0);
        #1;
        check("t2_port0", rdd_nb[31:0], 32'h2100_00CA);
        check("t2_port1", rdd_nb[63:32], 32'h0);

        // T3: same-cycle read of a register being written.
        set_rd(5'd7, 5'd7);
        wr0_en = 1'b1; wr0_addr = 5'd7; wr0_data = 32'h1234_5678;
        #1;
        check("t3_bypass_before", rdd_bp[31:0], 32'h1234_5678);
        check("t3_nobypass_before", rdd_nb[31:0], 32'h0);
        step();
        idle();
        #1;
        check("t3_nobypass_after", rdd_nb[31:0], 32'h1234_5678);

        // T4: collision on one address, then two independent addresses.
        set_rd(5'd3, 5'd3);
        wr0_en = 1'b1; wr0_addr = 5'd3; wr0_data = 32'hAAAA_0000;
        wr1_en = 1'b1; wr1_addr = 5'd3; wr1_data = 32'h0000_BBBB;
        #1;
        check("t4_bypass_priority", rdd_bp[31:0], 32'h0000_BBBB);
        step();
        idle();
        #1;
        check("t4_collision", rdd_nb[63:32], 32'h0000_BBBB);
        wr0_en = 1'b1; wr0_addr = 5'd10; wr0_data = 32'h0000_0011;
        wr1_en = 1'b1; wr1_addr = 5'd11; wr1_data = 32'h0000_0022;
        step();
        idle();
        set_rd(5'd10, 5'd11);
        #1;
        check("t4_dual_port0", rdd_nb[31:0], 32'h0000_0011);
        check("t4_dual_port1", rdd_nb[63:32], 32'h0000_0022);

        // T5: register 0 ignores writes and busy sets.
        set_rd(5'd0, 5'd0);
        wr1_en = 1'b1; wr1_addr = 5'd0; wr1_data = 32'hDEAD_BEEF;
        busy_set_en = 1'b1; busy_set_addr = 5'd0;
        #1;
        check("t5_zero_bypass", rdd_bp[31:0], 32'h0);
        step();
        idle();
        #1;
        check("t5_zero_after", rdd_bp[63:32], 32'h0);
        check("t5_zero_busy", {30'h0, rdb_bp | rdb_nb}, 32'h0);

        // T6: scoreboard set, set-beats-clear, then a lone clear.
        set_rd(5'd2, 5'd9);
        busy_set_en = 1'b1; busy_set_addr = 5'd9;
        step();
        idle();
        #1;
        check("t6_busy_set", {31'h0, rdb_nb[1]}, 32'h1);
        wr0_en = 1'b1; wr0_addr = 5'd9; wr0_data = 32'h0000_0005;
        busy_set_en = 1'b1; busy_set_addr = 5'd9;
        #1;
        check("t6_set_wins_bypass", {31'h0, rdb_bp[1]}, 32'h1);
        step();
        idle();
        #1;
        check("t6_data", rdd_nb[63:32], 32'h0000_0005);
        check("t6_still_busy", {31'h0, rdb_nb[1]}, 32'h1);
        wr1_en = 1'b1; wr1_addr = 5'd9; wr1_data = 32'h0000_0077;
        #1;
        check("t6_clear_bypass", {31'h0, rdb_bp[1]}, 32'h0);
        check("t6_clear_nobypass", {31'h0, rdb_nb[1]}, 32'h1);
        step();
        idle();
        #1;
        check("t6_cleared", {30'h0, rdb_bp[1], rdb_nb[1]}, 32'h0);
        check("t6_new_data", rdd_bp[63:32], 32'h0000_0077);

        step(); step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
